k12a_mem_arbiter: RTL and testbench

K12A_MEM_ARBITER -- requirements
Module: k12a_mem_arbiter

---
 rtl/k12a.inc.sv | 14 +
 rtl/k12a_rr_arbiter2.sv | 21 ++
 rtl/k12a_mem_arbiter.sv | 163 ++++++++++++++++
 tb/tb_k12a_mem_arbiter.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/k12a.inc.sv
// Shared types and constants for the k12a memory arbiter: FSM states and port ids.
package k12a_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StSetup,
        StStrobe,
        StHold
    } state_e;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DBG = 1'b1;

endpackage

// File: rtl/k12a_rr_arbiter2.sv
// Two-way round-robin arbiter: a sole requester wins, a tie goes to the port not granted last.
module k12a_rr_arbiter2
    import k12a_mem_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] grant
);

    // Bit index equals port id: bit 0 is the CPU, bit 1 the debug port.
    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = (last_grant == PORT_CPU) ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/k12a_mem_arbiter.sv
// Two-port asynchronous SRAM/ROM bus arbiter with a SETUP/STROBE/HOLD access sequence.
// All memory strobes and enables come straight from flops, one cycle behind the FSM state.
module k12a_mem_arbiter
    import k12a_mem_arbiter_pkg::*;
#(
    parameter int unsigned STROBE_CYCLES = 2,
    parameter int unsigned RAM_BASE_BIT  = 15
) (
    input  logic        clock,
    input  logic        reset_n,

    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic        cpu_ack,

    input  logic        dbg_req,
    input  logic        dbg_we,
    input  logic [15:0] dbg_addr,
    input  logic [7:0]  dbg_wdata,
    output logic        dbg_ack,

    output logic [7:0]  rdata,

    output logic        mem_rom_ce_n,
    output logic        mem_ram_ce_n,
    output logic        mem_oe_n,
    output logic        mem_we_n,
    output logic [15:0] addr_out,
    output logic        addr_oe,
    output logic [7:0]  data_out,
    output logic        data_oe,
    input  logic [7:0]  data_in
);

    localparam logic [3:0] StrobeLast = 4'(STROBE_CYCLES - 1);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [15:0] addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        port_q, port_d;
    logic        last_q, last_d;

    logic [1:0]  grant;
    logic        gport;

    logic        rom_ce_n_d, ram_ce_n_d, oe_n_d, we_n_d;
    logic        addr_oe_d, data_oe_d, cpu_ack_d, dbg_ack_d;
    logic        active, ram_sel;

    k12a_rr_arbiter2 u_rr (
        .req        ({dbg_req, cpu_req}),
        .last_grant (last_q),
        .grant      (grant)
    );

    assign gport = grant[1] ? PORT_DBG : PORT_CPU;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= 16'h0000;
            wdata_q <= 8'h00;
            port_q  <= PORT_CPU;
            last_q  <= PORT_DBG;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            port_q  <= port_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        port_d  = port_q;
        last_d  = last_q;
        case (state_q)
            StIdle: begin
                if (|grant) begin
                    state_d = StSetup;
                    port_d  = gport;
                    last_d  = gport;
                    we_d    = (gport == PORT_DBG) ? dbg_we    : cpu_we;
                    addr_d  = (gport == PORT_DBG) ? dbg_addr  : cpu_addr;
                    wdata_d = (gport == PORT_DBG) ? dbg_wdata : cpu_wdata;
                end
            end
            StSetup: begin
                state_d = StStrobe;
                cnt_d   = StrobeLast;
            end
            StStrobe: begin
                if (cnt_q == 4'd0) begin
                    state_d = StHold;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StHold:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Writes to ROM run the full sequence but never pulse we_n.
    always_comb begin
        active     = (state_q != StIdle);
        ram_sel    = addr_q[RAM_BASE_BIT];
        rom_ce_n_d = !(active && !ram_sel);
        ram_ce_n_d = !(active && ram_sel);
        oe_n_d     = !((state_q == StStrobe) && !we_q);
        we_n_d     = !((state_q == StStrobe) && we_q && ram_sel);
        addr_oe_d  = active;
        data_oe_d  = active && we_q;
        cpu_ack_d  = (state_q == StHold) && (port_q == PORT_CPU);
        dbg_ack_d  = (state_q == StHold) && (port_q == PORT_DBG);
    end

    // state_q == StHold coincides with the last visible strobe cycle, so data_in is sampled
    // on the edge that closes it.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            mem_rom_ce_n <= 1'b1;
            mem_ram_ce_n <= 1'b1;
            mem_oe_n     <= 1'b1;
            mem_we_n     <= 1'b1;
            addr_oe      <= 1'b0;
            data_oe      <= 1'b0;
            addr_out     <= 16'h0000;
            data_out     <= 8'h00;
            cpu_ack      <= 1'b0;
            dbg_ack      <= 1'b0;
            rdata        <= 8'h00;
        end else begin
            mem_rom_ce_n <= rom_ce_n_d;
            mem_ram_ce_n <= ram_ce_n_d;
            mem_oe_n     <= oe_n_d;
            mem_we_n     <= we_n_d;
            addr_oe      <= addr_oe_d;
            data_oe      <= data_oe_d;
            addr_out     <= addr_q;
            data_out     <= wdata_q;
            cpu_ack      <= cpu_ack_d;
            dbg_ack      <= dbg_ack_d;
            if ((state_q == StHold) && !we_q) begin
                rdata <= data_in;
            end
        end
    end

endmodule

// File: tb/tb_k12a_mem_arbiter.sv
// Self-checking bench for k12a_mem_arbiter: directed vector table, multi-cycle corner
// sequences and randomized traffic against a phase-level reference model.
module tb_k12a_mem_arbiter;

    localparam int S = 2;

    logic        clock, reset_n;
    logic        cpu_req, cpu_we, cpu_ack;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        dbg_req, dbg_we, dbg_ack;
    logic [15:0] dbg_addr;
    logic [7:0]  dbg_wdata;
    logic [7:0]  rdata;
    logic        mem_rom_ce_n, mem_ram_ce_n, mem_oe_n, mem_we_n;
    logic [15:0] addr_out;
    logic        addr_oe;
    logic [7:0]  data_out;
    logic        data_oe;
    logic [7:0]  data_in;

    int n_chk  = 0;
    int n_fail = 0;
    bit mon_en = 0;
    logic model_last;

    typedef struct {
        logic        cpu_req, dbg_req, cpu_we, dbg_we;
        logic [15:0] cpu_addr, dbg_addr;
        logic [7:0]  cpu_wdata, dbg_wdata, din;
        logic        exp_port;
    } vec_t;

    vec_t tbl[6];

    k12a_mem_arbiter #(
        .STROBE_CYCLES (S),
        .RAM_BASE_BIT  (15)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .cpu_req      (cpu_req),
        .cpu_we       (cpu_we),
        .cpu_addr     (cpu_addr),
        .cpu_wdata    (cpu_wdata),
        .cpu_ack      (cpu_ack),
        .dbg_req      (dbg_req),
        .dbg_we       (dbg_we),
        .dbg_addr     (dbg_addr),
        .dbg_wdata    (dbg_wdata),
        .dbg_ack      (dbg_ack),
        .rdata        (rdata),
        .mem_rom_ce_n (mem_rom_ce_n),
        .mem_ram_ce_n (mem_ram_ce_n),
        .mem_oe_n     (mem_oe_n),
        .mem_we_n     (mem_we_n),
        .addr_out     (addr_out),
        .addr_oe      (addr_oe),
        .data_out     (data_out),
        .data_oe      (data_oe),
        .data_in      (data_in)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, got, exp);
        end
    endtask

    // Bus exclusions hold in every cycle once reset has settled the outputs.
    always @(negedge clock) begin
        if (mon_en) begin
            chk("mon oe_we_excl", 16'(!(!mem_oe_n && !mem_we_n)), 16'd1);
            chk("mon doe_oe_excl", 16'(!(data_oe && !mem_oe_n)), 16'd1);
            chk("mon one_ce", 16'(!(!mem_rom_ce_n && !mem_ram_ce_n)), 16'd1);
        end
    end

    task automatic drive_quiet();
        cpu_req = 0; dbg_req = 0; cpu_we = 0; dbg_we = 0;
        cpu_addr = 0; dbg_addr = 0; cpu_wdata = 0; dbg_wdata = 0;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, " rom_ce_n"}, 16'(mem_rom_ce_n), 16'd1);
        chk({tag, " ram_ce_n"}, 16'(mem_ram_ce_n), 16'd1);
        chk({tag, " oe_n"}, 16'(mem_oe_n), 16'd1);
        chk({tag, " we_n"}, 16'(mem_we_n), 16'd1);
        chk({tag, " addr_oe"}, 16'(addr_oe), 16'd0);
        chk({tag, " data_oe"}, 16'(data_oe), 16'd0);
        chk({tag, " cpu_ack"}, 16'(cpu_ack), 16'd0);
        chk({tag, " dbg_ack"}, 16'(dbg_ack), 16'd0);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset_n = 0;
        drive_quiet();
        data_in = 8'h00;
        @(negedge clock);
        check_idle("reset");
        chk("reset rdata", 16'(rdata), 16'h0000);
        chk("reset addr_out", addr_out, 16'h0000);
        chk("reset data_out", 16'(data_out), 16'h0000);
        @(negedge clock);
        reset_n = 1;
        model_last = 1'b1;
        @(negedge clock);
        check_idle("post_reset");
    endtask

    // Phase 1 = SETUP, 2..S+1 = STROBE, S+2 = HOLD, all as seen on the outputs.
    task automatic check_phase(input int p, input vec_t v);
        logic        w, we, rom, strobe, hold;
        logic [15:0] a;
        logic [7:0]  wd;
        string       t;
        w      = v.exp_port;
        we     = w ? v.dbg_we : v.cpu_we;
        a      = w ? v.dbg_addr : v.cpu_addr;
        wd     = w ? v.dbg_wdata : v.cpu_wdata;
        rom    = !a[15];
        strobe = (p >= 2) && (p <= S + 1);
        hold   = (p == S + 2);
        t      = $sformatf("p%0d", p);
        chk({t, " rom_ce_n"}, 16'(mem_rom_ce_n), 16'(!rom));
        chk({t, " ram_ce_n"}, 16'(mem_ram_ce_n), 16'(rom));
        chk({t, " oe_n"}, 16'(mem_oe_n), 16'(!(strobe && !we)));
        chk({t, " we_n"}, 16'(mem_we_n), 16'(!(strobe && we && !rom)));
        chk({t, " addr_oe"}, 16'(addr_oe), 16'd1);
        chk({t, " addr_out"}, addr_out, a);
        chk({t, " data_oe"}, 16'(data_oe), 16'(we));
        if (we) chk({t, " data_out"}, 16'(data_out), 16'(wd));
        chk({t, " cpu_ack"}, 16'(cpu_ack), 16'(hold && !w));
        chk({t, " dbg_ack"}, 16'(dbg_ack), 16'(hold && w));
        if (hold && !we) chk({t, " rdata"}, 16'(rdata), 16'(v.din));
    endtask

    // Presents the request for one edge only, so each transaction also exercises
    // a request withdrawn mid-transaction.
    task automatic run_txn(input vec_t v);
        cpu_req = v.cpu_req; cpu_we = v.cpu_we; cpu_addr = v.cpu_addr; cpu_wdata = v.cpu_wdata;
        dbg_req = v.dbg_req; dbg_we = v.dbg_we; dbg_addr = v.dbg_addr; dbg_wdata = v.dbg_wdata;
        data_in = v.din;
        @(posedge clock);
        @(negedge clock);
        cpu_req = 0;
        dbg_req = 0;
        check_idle("grant_cycle");
        for (int p = 1; p <= S + 2; p++) begin
            @(negedge clock);
            check_phase(p, v);
        end
        @(negedge clock);
        check_idle("after_hold");
    endtask

    function automatic logic model_pick(input logic c, input logic d);
        if (c && !d) return 1'b0;
        if (d && !c) return 1'b1;
        return !model_last;
    endfunction

    initial begin
        reset_n = 0;
        drive_quiet();
        data_in = 0;
        model_last = 1'b1;

        //              creq dreq cwe dwe  caddr     daddr     cwd    dwd    din    port
        tbl[0] = '{1, 0, 0, 0, 16'h0123, 16'h0000, 8'h00, 8'h00, 8'hA5, 0};
        tbl[1] = '{0, 1, 0, 1, 16'h0000, 16'h8040, 8'h00, 8'h3C, 8'h00, 1};
        tbl[2] = '{1, 1, 0, 1, 16'h8001, 16'h8002, 8'h11, 8'h22, 8'h5E, 0};
        tbl[3] = '{1, 1, 1, 0, 16'h8003, 16'h0004, 8'h33, 8'h44, 8'hC7, 1};
        tbl[4] = '{1, 0, 1, 0, 16'h0010, 16'h0000, 8'h99, 8'h00, 8'h00, 0};
        tbl[5] = '{0, 1, 0, 0, 16'h0000, 16'hFFFF, 8'h00, 8'h00, 8'h6B, 1};

        repeat (2) @(negedge clock);
        check_idle("init");
        chk("init rdata", 16'(rdata), 16'h0000);
        mon_en = 1;
        do_reset();

        for (int i = 0; i < 6; i++) begin
            run_txn(tbl[i]);
        end

        // Continuous tie: grants alternate cpu, dbg, ... every S+3 cycles.
        do_reset();
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0200;
        dbg_req = 1; dbg_we = 1; dbg_addr = 16'h8300; dbg_wdata = 8'h5A;
        data_in = 8'h77;
        @(posedge clock);
        begin
            logic exp_w;
            bit   is_ack;
            exp_w = 1'b0;
            for (int c = 1; c <= 4 * (S + 3); c++) begin
                @(negedge clock);
                is_ack = (c % (S + 3)) == 0;
                chk($sformatf("tie c%0d cpu_ack", c), 16'(cpu_ack), 16'(is_ack && !exp_w));
                chk($sformatf("tie c%0d dbg_ack", c), 16'(dbg_ack), 16'(is_ack && exp_w));
                if (is_ack) begin
                    chk("tie addr_out", addr_out, exp_w ? 16'h8300 : 16'h0200);
                    if (!exp_w) chk("tie rdata", 16'(rdata), 16'h0077);
                    exp_w = !exp_w;
                end
            end
            cpu_req = 0;
            dbg_req = 0;
            @(negedge clock);
            check_idle("tie_end");
        end

        // Reset during STROBE aborts the read with no ack.
        do_reset();
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h8123; data_in = 8'hE1;
        @(posedge clock);
        @(negedge clock);
        cpu_req = 0;
        @(negedge clock);
        @(negedge clock);
        chk("abort in_strobe oe_n", 16'(mem_oe_n), 16'd0);
        reset_n = 0;
        @(negedge clock);
        check_idle("abort");
        chk("abort rdata", 16'(rdata), 16'h0000);
        reset_n = 1;
        for (int c = 0; c < S + 4; c++) begin
            @(negedge clock);
            check_idle("abort_quiet");
        end

        // Randomized traffic against the arbitration and phase model.
        do_reset();
        for (int n = 0; n < 40; n++) begin
            vec_t v;
            int   mode, gap;
            gap = int'($urandom_range(0, 3));
            for (int g = 0; g < gap; g++) begin
                @(negedge clock);
                check_idle("rand_gap");
            end
            mode        = int'($urandom_range(0, 2));
            v.cpu_req   = (mode != 1);
            v.dbg_req   = (mode != 0);
            v.cpu_we    = 1'($urandom);
            v.dbg_we    = 1'($urandom);
            v.cpu_addr  = 16'($urandom);
            v.dbg_addr  = 16'($urandom);
            v.cpu_wdata = 8'($urandom);
            v.dbg_wdata = 8'($urandom);
            v.din       = 8'($urandom);
            v.exp_port  = model_pick(v.cpu_req, v.dbg_req);
            model_last  = v.exp_port;
            run_txn(v);
        end

        mon_en = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
